// File: rtl/uart_disp_defs.sv
// Shared definitions for the UART hex display: read FSM states, control
// characters and the active-high 7-segment glyph table.
package uart_disp_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PROC = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_BS  = 8'h08;

    // Glyphs indexed by digit value, segment a on bit 0 through g on bit 6.
    localparam logic [6:0] SEG_MAP [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-digit to active-high segment pattern, with blanking.
module hex_to_7seg
    import uart_disp_defs::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : SEG_MAP[value_i];

endmodule

// File: rtl/uart_hex_display.sv
// Pops bytes from a UART receive FIFO, shifts ASCII hex characters into a
// 4-digit register and scans it onto a common-anode 7-segment display.
module uart_hex_display
    import uart_disp_defs::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int SCAN_WIDTH  = 17,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_empty,
    input  logic [7:0] rd_data,
    output logic       rd_uart,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       err
);

    localparam logic [SCAN_WIDTH-1:0] SCAN_LAST = SCAN_WIDTH'(SCAN_DIV - 1);
    localparam logic [6:0]            SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = SEG_ACT_LOW;

    state_e                state_q, state_d;
    logic [7:0]            byte_q, byte_d;
    logic [3:0]            digit_q [4];
    logic [3:0]            digit_d [4];
    logic [3:0]            blank_q, blank_d;
    logic                  err_q, err_d;
    logic [SCAN_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    logic                  is_hex;
    logic [3:0]            hex_val;
    logic [6:0]            seg_raw;
    logic                  dp_raw;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: if (!rx_empty) state_d = ST_POP;
            ST_POP: begin
                byte_d  = rd_data;
                state_d = ST_PROC;
            end
            ST_PROC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_uart = (state_q == ST_POP);

    // Letters sit at x1..x6 in both cases, so low nibble + 9 gives 10..15.
    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'd0;
        case (byte_q) inside
            [8'h30:8'h39]: begin
                is_hex  = 1'b1;
                hex_val = byte_q[3:0];
            end
            [8'h41:8'h46], [8'h61:8'h66]: begin
                is_hex  = 1'b1;
                hex_val = byte_q[3:0] + 4'd9;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];
        blank_d = blank_q;
        err_d   = err_q;
        if (state_q == ST_PROC) begin
            if (is_hex) begin
                for (int i = 1; i < 4; i++) digit_d[i] = digit_q[i-1];
                digit_d[0] = hex_val;
                blank_d    = {blank_q[2:0], 1'b0};
                err_d      = 1'b0;
            end else if (byte_q == ASCII_CR || byte_q == ASCII_LF) begin
                err_d = err_q;
            end else if (byte_q == ASCII_ESC) begin
                blank_d = 4'hF;
                err_d   = 1'b0;
            end else if (byte_q == ASCII_BS) begin
                for (int i = 0; i < 3; i++) digit_d[i] = digit_q[i+1];
                digit_d[3] = 4'd0;
                blank_d    = {1'b1, blank_q[3:1]};
                err_d      = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .value_i (digit_q[idx_q]),
        .blank_i (blank_q[idx_q]),
        .seg_o   (seg_raw)
    );

    assign dp_raw = err_q & (idx_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            blank_q <= 4'hF;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
            blank_q <= blank_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= ~(4'b0001 << idx_q);
            seg_q   <= SEG_ACT_LOW ? ~seg_raw : seg_raw;
            dp_q    <= SEG_ACT_LOW ? ~dp_raw : dp_raw;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign err = err_q;

endmodule

// File: tb/tb_uart_hex_display.sv
// Bench for uart_hex_display: FIFO model, digit reference model, table vectors,
// random byte streams and a reset-during-pop sequence.
module tb_uart_hex_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       rd_uart;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;

    always #5 clk = ~clk;

    uart_hex_display #(
        .SCAN_DIV    (4),
        .SCAN_WIDTH  (2),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_empty (rx_empty),
        .rd_data  (rd_data),
        .rd_uart  (rd_uart),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .err      (err)
    );

    typedef struct {
        logic [7:0]  ch;
        logic [15:0] val;
        logic [3:0]  blank;
        logic        err;
    } vec_t;

    logic [6:0] segm [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo [$];
    int         pops = 0;
    int         gcyc = 0;
    int         last_pop = -100;
    int         n = 0;
    logic       drop_on_reset = 1'b0;

    // Reference model: digit values 0..15, or -1 for blank.
    int         mdig [4];
    logic       merr;

    logic [15:0] exp_val;
    logic [3:0]  exp_blank;
    logic        exp_err;

    always @(posedge clk) gcyc <= gcyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    always @(negedge clk) begin
        rx_empty <= (fifo.size() == 0);
        rd_data  <= (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    function automatic int hexval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 32'h30;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 32'h41 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 32'h61 + 10;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mdig[i] = -1;
            merr = 1'b0;
            if (drop_on_reset && fifo.size() != 0) void'(fifo.pop_front());
        end else if (rd_uart) begin
            logic [7:0] b;
            int         v;
            total++;
            if (rx_empty || (gcyc - last_pop) < 3) begin
                bad++;
                $display("FAIL pop_rule: empty=%0b spacing=%0d required empty=0 spacing>=3",
                         rx_empty, gcyc - last_pop);
            end
            last_pop = gcyc;
            pops++;
            b = (fifo.size() != 0) ? fifo.pop_front() : 8'h00;
            v = hexval(b);
            if (v >= 0) begin
                for (int i = 3; i > 0; i--) mdig[i] = mdig[i-1];
                mdig[0] = v;
                merr = 1'b0;
            end else if (b == 8'h0D || b == 8'h0A) begin
                merr = merr;
            end else if (b == 8'h1B) begin
                for (int i = 0; i < 4; i++) mdig[i] = -1;
                merr = 1'b0;
            end else if (b == 8'h08) begin
                for (int i = 0; i < 3; i++) mdig[i] = mdig[i+1];
                mdig[3] = -1;
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic wait_drain(input int limit);
        int k;
        k = 0;
        while (fifo.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (fifo.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: left=%0d required 0", fifo.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic load_model_exp();
        exp_blank = '0;
        exp_val   = '0;
        for (int i = 0; i < 4; i++) begin
            if (mdig[i] < 0) exp_blank[i] = 1'b1;
            else             exp_val[i*4 +: 4] = mdig[i][3:0];
        end
        exp_err = merr;
    endtask

    task automatic check_display(input string tag);
        logic [3:0] one;
        logic [6:0] es;
        int         idx;
        one = 4'b0001;
        chk({tag, "_err"}, {15'd0, err}, {15'd0, exp_err});
        repeat (16) begin
            @(negedge clk);
            idx = ((n - 1) / 4) % 4;
            chk({tag, "_an"}, {12'd0, an}, {12'd0, ~(one << idx)});
            es = exp_blank[idx] ? 7'h7F : ~segm[exp_val[idx*4 +: 4]];
            chk({tag, "_seg"}, {9'd0, seg}, {9'd0, es});
            chk({tag, "_dp"}, {15'd0, dp}, {15'd0, ~(exp_err && idx == 0)});
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r, k;
        r = $urandom_range(0, 15);
        if (r < 8) begin
            k = $urandom_range(0, 21);
            if (k < 10)      return 8'(32'h30 + k);
            else if (k < 16) return 8'(32'h41 + k - 10);
            else             return 8'(32'h61 + k - 16);
        end
        if (r == 8)  return 8'h0D;
        if (r == 9)  return 8'h0A;
        if (r == 10) return 8'h1B;
        if (r < 13)  return 8'h08;
        return 8'($urandom_range(0, 255));
    endfunction

    vec_t tbl [17];

    initial begin
        int p0, k;

        tbl[0]  = '{8'h31, 16'h0001, 4'b1110, 1'b0};
        tbl[1]  = '{8'h32, 16'h0012, 4'b1100, 1'b0};
        tbl[2]  = '{8'h33, 16'h0123, 4'b1000, 1'b0};
        tbl[3]  = '{8'h34, 16'h1234, 4'b0000, 1'b0};
        tbl[4]  = '{8'h61, 16'h234A, 4'b0000, 1'b0};
        tbl[5]  = '{8'h5A, 16'h234A, 4'b0000, 1'b1};
        tbl[6]  = '{8'h35, 16'h34A5, 4'b0000, 1'b0};
        tbl[7]  = '{8'h0D, 16'h34A5, 4'b0000, 1'b0};
        tbl[8]  = '{8'h5A, 16'h34A5, 4'b0000, 1'b1};
        tbl[9]  = '{8'h0A, 16'h34A5, 4'b0000, 1'b1};
        tbl[10] = '{8'h08, 16'h034A, 4'b1000, 1'b0};
        tbl[11] = '{8'h1B, 16'h0000, 4'b1111, 1'b0};
        tbl[12] = '{8'h31, 16'h0001, 4'b1110, 1'b0};
        tbl[13] = '{8'h32, 16'h0012, 4'b1100, 1'b0};
        tbl[14] = '{8'h33, 16'h0123, 4'b1000, 1'b0};
        tbl[15] = '{8'h34, 16'h1234, 4'b0000, 1'b0};
        tbl[16] = '{8'h08, 16'h0123, 4'b1000, 1'b0};

        // Reset state while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_rd_uart", {15'd0, rd_uart}, 16'd0);
        chk("rst_an", {12'd0, an}, 16'h000F);
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_dp", {15'd0, dp}, 16'd1);
        chk("rst_err", {15'd0, err}, 16'd0);
        rst_n = 1'b1;

        // Idle scan with no data: blank digits, no pops.
        exp_val = '0; exp_blank = 4'hF; exp_err = 1'b0;
        check_display("idle");
        chk("idle_pops", 16'(pops), 16'd0);
        $display("idle scan checked");

        for (int i = 0; i < 17; i++) begin
            p0 = pops;
            @(negedge clk);
            fifo.push_back(tbl[i].ch);
            wait_drain(50);
            chk("vec_pops", 16'(pops - p0), 16'd1);
            exp_val = tbl[i].val; exp_blank = tbl[i].blank; exp_err = tbl[i].err;
            check_display("vec");
            $display("vec %0d byte=%h digits=%h blank=%b err=%0b", i, tbl[i].ch,
                     tbl[i].val, tbl[i].blank, tbl[i].err);
        end

        // Back-to-back random batches checked against the reference model.
        for (int b = 0; b < 4; b++) begin
            p0 = pops;
            @(negedge clk);
            for (int j = 0; j < 12; j++) fifo.push_back(rand_byte());
            wait_drain(200);
            chk("rand_pops", 16'(pops - p0), 16'd12);
            load_model_exp();
            check_display("rand");
            $display("rand batch %0d digits=%h blank=%b err=%0b", b, exp_val, exp_blank, exp_err);
        end

        // Put known digits up, then reset while the FSM is in POP.
        @(negedge clk);
        fifo.push_back(8'h39);
        wait_drain(50);
        p0 = pops;
        @(negedge clk);
        fifo.push_back(8'h37);
        k = 0;
        while (!rd_uart && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pop_seen", {15'd0, rd_uart}, 16'd1);
        drop_on_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rd_uart", {15'd0, rd_uart}, 16'd0);
        chk("mid_an", {12'd0, an}, 16'h000F);
        chk("mid_seg", {9'd0, seg}, 16'h007F);
        chk("mid_dp", {15'd0, dp}, 16'd1);
        chk("mid_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drop_on_reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_no_pop", 16'(pops - p0), 16'd0);
        exp_val = '0; exp_blank = 4'hF; exp_err = 1'b0;
        check_display("mid");
        $display("reset during pop checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
